// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing helpers for the program loader
package imem_loader_pkg;

    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    localparam int LEN_WIDTH = 16;

    function automatic int bpw(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into words and pulses word_valid once per completed word
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    input  logic                  valid,
    output logic                  last,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int BPW = bpw(DATA_WIDTH);
    localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;

    logic [CW-1:0] byte_cnt;

    assign last = byte_cnt == CW'(BPW - 1);

    // Byte lane fill; the strobe follows the final byte of a word by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= valid & last;
            if (clear) begin
                byte_cnt <= '0;
                word     <= '0;
            end else if (valid) begin
                word[{byte_cnt, 3'b000} +: 8] <= byte_in;
                byte_cnt <= last ? '0 : byte_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory (optional trailer checksum: IMEM_LOADER_CHECKSUM_EN)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic                     start,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     load_done,
    output logic                     load_err,
    output logic                     cpu_hold
);

    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(1) << ADDRESS_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif

    state_t                 state, state_nx;
    logic [LEN_WIDTH-1:0]   len, len_full, word_nxt;
    logic [ADDRESS_WIDTH:0] word_cnt;
    logic                   acc, wa_valid, wa_last, clr;

    assign acc      = rx_valid & rx_ready;
    assign wa_valid = acc & (state == DATA);
    assign clr      = start & (state == DONE || state == ERR);
    assign len_full = {rx_data, len[7:0]};
    assign word_nxt = LEN_WIDTH'(word_cnt) + LEN_WIDTH'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    // Running modulo-256 sum over length and data bytes; the trailer is judged, not added
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sum <= '0;
        else if (clr)
            sum <= '0;
        else if (acc && state != CSUM)
            sum <= sum + rx_data;
    end
`endif

    // Next-state: the last word is detected on its final byte so the write and DONE coincide
    always_comb begin
        state_nx = state;
        case (state)
            LEN_LO: if (acc) state_nx = LEN_HI;
            LEN_HI: if (acc) state_nx = len_full == '0 ? FIN : {1'b0, len_full} > MAX_LEN ? ERR : DATA;
            DATA:   if (wa_valid && wa_last && word_nxt == len) state_nx = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:   if (acc) state_nx = 8'(sum + rx_data) == 8'h00 ? DONE : ERR;
`else
            CSUM:   state_nx = ERR;
`endif
            default: if (clr) state_nx = LEN_LO;
        endcase
    end

    // State, length, word counter and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LEN_LO;
            len       <= '0;
            word_cnt  <= '0;
            mem_addr  <= '0;
            rx_ready  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            state     <= state_nx;
            rx_ready  <= state_nx inside {LEN_LO, LEN_HI, DATA, CSUM};
            load_done <= state_nx == DONE;
            load_err  <= state_nx == ERR;
            cpu_hold  <= state_nx != DONE;
            if (clr) begin
                len      <= '0;
                word_cnt <= '0;
            end
            if (acc && state == LEN_LO)
                len[7:0] <= rx_data;
            if (acc && state == LEN_HI)
                len[LEN_WIDTH-1:8] <= rx_data;
            if (wa_valid && wa_last) begin
                mem_addr <= word_cnt[ADDRESS_WIDTH-1:0];
                word_cnt <= word_cnt + (ADDRESS_WIDTH + 1)'(1);
            end
        end
    end

    word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (clr),
        .byte_in    (rx_data),
        .valid      (wa_valid),
        .last       (wa_last),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

endmodule
